// File: rtl/rca_config.sv
// Load/store queue types: queued entry layout and the issue FSM states.
package rca_config;

    import taiga_config::*;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [2:0]      fn3;
        logic            is_load;
    } lsq_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RETURN  = 2'd3
    } lsq_state_t;

endpackage

// File: rtl/taiga_config.sv
// Core-wide configuration shared by the Taiga-derived units.
package taiga_config;

    localparam int XLEN = 32;

endpackage

// File: rtl/rca_lsq_align.sv
// Byte-lane steering: byte enables and write replication for stores,
// lane select plus sign/zero extension for loads.
module rca_lsq_align
    import taiga_config::*;
(
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      fn3,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] read_data,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_result
);

    logic [XLEN-1:0] shifted;

    // Misaligned half/word accesses are passed through unchecked.
    assign shifted = read_data >> {addr_lo, 3'b000};

    always_comb begin
        be          = 4'b1111;
        wdata       = store_data;
        load_result = read_data;
        case (fn3[1:0])
            2'b00: begin
                be          = 4'b0001 << addr_lo;
                wdata       = {4{store_data[7:0]}};
                load_result = {{(XLEN-8){~fn3[2] & shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                be          = 4'b0011 << addr_lo;
                wdata       = {2{store_data[15:0]}};
                load_result = {{(XLEN-16){~fn3[2] & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                be          = 4'b1111;
                wdata       = store_data;
                load_result = read_data;
            end
        endcase
    end

endmodule

// File: rtl/rca_lsq.sv
// In-order load/store queue with a single outstanding memory transaction
// and a valid/ack return path for load results.
module rca_lsq
    import taiga_config::*;
    import rca_config::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [XLEN-1:0]          addr,
    input  logic [XLEN-1:0]          data,
    input  logic [2:0]               fn3,
    input  logic                     load,
    input  logic                     store,
    input  logic                     new_request,
    output logic                     lsq_full,
    output logic [XLEN-1:0]          mem_addr,
    output logic [XLEN-1:0]          mem_wdata,
    output logic [3:0]               mem_be,
    output logic                     mem_rnw,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    input  logic [XLEN-1:0]          mem_rdata,
    input  logic                     mem_rvalid,
    output logic [XLEN-1:0]          load_data,
    output logic                     load_data_valid,
    input  logic                     load_data_ack,
    output lsq_state_t               fsm_state,
    output logic [$clog2(DEPTH):0]   entry_count
);

    // Handshakes: a memory request transfers on a clk edge with
    // mem_req_valid & mem_req_ready; a load result transfers on an edge
    // with load_data_valid & load_data_ack. Valid is never withdrawn and
    // its payload never changes until the transfer happens.

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] ONE  = (PW+1)'(1);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    lsq_entry_t      entries [DEPTH];
    lsq_entry_t      head_entry;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW:0]     count;
    lsq_state_t      state;
    lsq_state_t      state_next;
    logic            enq;
    logic            deq;
    logic            capture;
    logic [XLEN-1:0] load_result;
    logic [XLEN-1:0] load_data_r;

    assign lsq_full   = (count == FULL);
    assign enq        = new_request & ~lsq_full & (load ^ store);
    assign head_entry = entries[head];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries[tail] <= '{addr: addr, data: data, fn3: fn3, is_load: load};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    rca_lsq_align u_align (
        .addr_lo     (head_entry.addr[1:0]),
        .fn3         (head_entry.fn3),
        .store_data  (head_entry.data),
        .read_data   (mem_rdata),
        .be          (mem_be),
        .wdata       (mem_wdata),
        .load_result (load_result)
    );

    assign mem_addr = {head_entry.addr[XLEN-1:2], 2'b00};
    assign mem_rnw  = head_entry.is_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        deq             = 1'b0;
        capture         = 1'b0;
        mem_req_valid   = 1'b0;
        load_data_valid = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) state_next = ISSUE;
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    if (head_entry.is_load) begin
                        state_next = WAIT_RD;
                    end else begin
                        deq        = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            WAIT_RD: begin
                if (mem_rvalid) begin
                    capture    = 1'b1;
                    state_next = RETURN;
                end
            end
            RETURN: begin
                load_data_valid = 1'b1;
                if (load_data_ack) begin
                    deq        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result is held from capture until the next load completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_data_r <= '0;
        end else if (capture) begin
            load_data_r <= load_result;
        end
    end

    assign load_data   = load_data_r;
    assign fsm_state   = state;
    assign entry_count = count;

endmodule

// File: tb/tb_rca_lsq.sv
// Directed bench for rca_lsq: reset, store/load alignment, fill, back-pressure,
// mid-transaction reset and invalid requests.
module tb_rca_lsq;

    import rca_config::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] data = '0;
    logic [2:0]  fn3 = '0;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic        new_request = 1'b0;
    logic        lsq_full;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rnw;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] load_data;
    logic        load_data_valid;
    logic        load_data_ack = 1'b0;
    lsq_state_t  fsm_state;
    logic [2:0]  entry_count;

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    rca_lsq #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .fn3(fn3),
        .load(load), .store(store), .new_request(new_request),
        .lsq_full(lsq_full), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rnw(mem_rnw), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .load_data(load_data),
        .load_data_valid(load_data_valid), .load_data_ack(load_data_ack),
        .fsm_state(fsm_state), .entry_count(entry_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enqueue(input logic ld, input logic st, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f);
        addr = a; data = d; fn3 = f; load = ld; store = st;
        new_request = 1'b1;
        step();
        new_request = 1'b0; load = 1'b0; store = 1'b0;
    endtask

    task automatic wait_issue(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!ok && mem_req_valid) ok = 1'b1;
            if (!ok) step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++; if (lsq_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", lsq_full); else passed++;
        checks++; if (mem_req_valid !== 1'b0) $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); else passed++;
        checks++; if (load_data_valid !== 1'b0) $display("FAIL reset_ld_valid got=%b exp=0", load_data_valid); else passed++;
        checks++; if (load_data !== 32'h0) $display("FAIL reset_load_data got=%h exp=0", load_data); else passed++;
        checks++; if (entry_count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", entry_count); else passed++;
        checks++; if (fsm_state !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", fsm_state, IDLE); else passed++;
    endtask

    task automatic test_store(input string name, input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] f, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        bit ok;
        enqueue(1'b0, 1'b1, a, d, f);
        wait_issue(ok);
        checks++; if (!ok) $display("FAIL %s_issue_timeout got=0 exp=1", name); else passed++;
        checks++; if (mem_addr !== exp_addr) $display("FAIL %s_addr got=%h exp=%h", name, mem_addr, exp_addr); else passed++;
        checks++; if (mem_be !== exp_be) $display("FAIL %s_be got=%b exp=%b", name, mem_be, exp_be); else passed++;
        checks++; if (mem_wdata !== exp_wdata) $display("FAIL %s_wdata got=%h exp=%h", name, mem_wdata, exp_wdata); else passed++;
        checks++; if (mem_rnw !== 1'b0) $display("FAIL %s_rnw got=%b exp=0", name, mem_rnw); else passed++;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        checks++; if (entry_count !== 3'd0 || fsm_state !== IDLE)
            $display("FAIL %s_dequeue got=count %0d state %0d exp=count 0 state 0", name, entry_count, fsm_state);
        else passed++;
    endtask

    task automatic test_load(input string name, input logic [31:0] a, input logic [2:0] f,
                             input logic [31:0] rdata, input logic [31:0] exp_addr,
                             input logic [3:0] exp_be, input logic [31:0] exp_data);
        bit ok;
        enqueue(1'b1, 1'b0, a, 32'h0, f);
        wait_issue(ok);
        checks++; if (!ok) $display("FAIL %s_issue_timeout got=0 exp=1", name); else passed++;
        checks++; if (mem_addr !== exp_addr) $display("FAIL %s_addr got=%h exp=%h", name, mem_addr, exp_addr); else passed++;
        checks++; if (mem_be !== exp_be || mem_rnw !== 1'b1)
            $display("FAIL %s_be_rnw got=%b/%b exp=%b/1", name, mem_be, mem_rnw, exp_be);
        else passed++;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        checks++; if (fsm_state !== WAIT_RD) $display("FAIL %s_wait_state got=%0d exp=%0d", name, fsm_state, WAIT_RD); else passed++;
        mem_rdata = rdata; mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        checks++; if (load_data_valid !== 1'b1 || load_data !== exp_data)
            $display("FAIL %s_result got=%b/%h exp=1/%h", name, load_data_valid, load_data, exp_data);
        else passed++;
        load_data_ack = 1'b1;
        step();
        load_data_ack = 1'b0;
        checks++; if (entry_count !== 3'd0 || fsm_state !== IDLE || load_data_valid !== 1'b0)
            $display("FAIL %s_retire got=count %0d state %0d exp=count 0 state 0", name, entry_count, fsm_state);
        else passed++;
    endtask

    task automatic test_fill();
        int issued = 0;
        mem_req_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            enqueue(1'b0, 1'b1, 32'h10 + 32'(4 * i), 32'(i), 3'b010);
            exp_q.push_back(32'h10 + 32'(4 * i));
        end
        checks++; if (lsq_full !== 1'b1 || entry_count !== 3'd4)
            $display("FAIL fill_full got=%b/%0d exp=1/4", lsq_full, entry_count);
        else passed++;
        enqueue(1'b0, 1'b1, 32'h20, 32'h99, 3'b010);
        checks++; if (entry_count !== 3'd4) $display("FAIL fill_drop5 got=%0d exp=4", entry_count); else passed++;
        mem_req_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (mem_req_valid) begin
                issued++;
                checks++;
                if (exp_q.size() == 0) $display("FAIL fill_extra got=%h exp=none", mem_addr);
                else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (mem_addr !== e) $display("FAIL fill_order got=%h exp=%h", mem_addr, e); else passed++;
                end
            end
            step();
        end
        mem_req_ready = 1'b0;
        checks++; if (issued != 4 || entry_count !== 3'd0)
            $display("FAIL fill_drain got=%0d/%0d exp=4/0", issued, entry_count);
        else passed++;
    endtask

    task automatic test_back_pressure();
        bit ok;
        bit stable = 1'b1;
        enqueue(1'b1, 1'b0, 32'h500, 32'h0, 3'b010);
        wait_issue(ok);
        checks++; if (!ok) $display("FAIL bp_issue_timeout got=0 exp=1"); else passed++;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        enqueue(1'b0, 1'b1, 32'h504, 32'h11, 3'b010);
        checks++; if (entry_count !== 3'd2 || fsm_state !== WAIT_RD)
            $display("FAIL bp_enq_outstanding got=%0d/%0d exp=2/%0d", entry_count, fsm_state, WAIT_RD);
        else passed++;
        mem_rdata = 32'hCAFEF00D; mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            mem_rdata = $urandom;
            if (load_data !== 32'hCAFEF00D || load_data_valid !== 1'b1 ||
                mem_req_valid !== 1'b0 || fsm_state !== RETURN) stable = 1'b0;
            step();
        end
        checks++; if (!stable) $display("FAIL bp_hold got=%h/%b exp=cafef00d/1", load_data, load_data_valid); else passed++;
        load_data_ack = 1'b1;
        step();
        load_data_ack = 1'b0;
        checks++; if (entry_count !== 3'd1) $display("FAIL bp_ack_deq got=%0d exp=1", entry_count); else passed++;
        wait_issue(ok);
        checks++; if (!ok || mem_addr !== 32'h504 || mem_rnw !== 1'b0)
            $display("FAIL bp_next_issue got=%b/%h exp=1/00000504", ok, mem_addr);
        else passed++;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        enqueue(1'b1, 1'b0, 32'h600, 32'h0, 3'b010);
        enqueue(1'b1, 1'b0, 32'h604, 32'h0, 3'b010);
        wait_issue(ok);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        checks++; if (!ok || fsm_state !== WAIT_RD || entry_count !== 3'd2)
            $display("FAIL rstmid_setup got=%0d/%0d exp=%0d/2", fsm_state, entry_count, WAIT_RD);
        else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (entry_count !== 3'd0 || fsm_state !== IDLE || mem_req_valid !== 1'b0)
            $display("FAIL rstmid_clear got=%0d/%0d exp=0/0", entry_count, fsm_state);
        else passed++;
        mem_rdata = 32'h12345678; mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        step();
        checks++; if (fsm_state !== IDLE || load_data_valid !== 1'b0 || load_data !== 32'h0)
            $display("FAIL rstmid_late_rvalid got=%0d/%b/%h exp=0/0/0", fsm_state, load_data_valid, load_data);
        else passed++;
    endtask

    task automatic test_invalid();
        enqueue(1'b1, 1'b1, 32'h700, 32'h1, 3'b010);
        checks++; if (entry_count !== 3'd0) $display("FAIL invalid_both got=%0d exp=0", entry_count); else passed++;
        enqueue(1'b0, 1'b0, 32'h704, 32'h2, 3'b010);
        step();
        checks++; if (entry_count !== 3'd0 || fsm_state !== IDLE || mem_req_valid !== 1'b0)
            $display("FAIL invalid_none got=%0d/%0d exp=0/0", entry_count, fsm_state);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_store("st_word", 32'h100, 32'hDEADBEEF, 3'b010, 32'h100, 4'b1111, 32'hDEADBEEF);
        test_store("st_byte", 32'h401, 32'h000000A5, 3'b000, 32'h400, 4'b0010, 32'hA5A5A5A5);
        test_store("st_half", 32'h402, 32'h1234BEEF, 3'b001, 32'h400, 4'b1100, 32'hBEEFBEEF);
        test_load("ld_b", 32'h203, 3'b000, 32'h80FFFFFF, 32'h200, 4'b1000, 32'hFFFFFF80);
        test_load("ld_bu", 32'h203, 3'b100, 32'h80FFFFFF, 32'h200, 4'b1000, 32'h00000080);
        test_load("ld_h", 32'h302, 3'b001, 32'h80011234, 32'h300, 4'b1100, 32'hFFFF8001);
        test_load("ld_hu", 32'h302, 3'b101, 32'h80011234, 32'h300, 4'b1100, 32'h00008001);
        test_load("ld_w", 32'h304, 3'b010, 32'h89ABCDEF, 32'h304, 4'b1111, 32'h89ABCDEF);
        test_fill();
        test_back_pressure();
        test_reset_mid();
        test_invalid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rca_lsq.md
RCA_LSQ -- requirements
Module: rca_lsq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of queue entries (power of two, at least 2).
REQ-002 SHALL use XLEN from taiga_config for all data and address widths.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port addr, input, XLEN: request byte address from the PR unit.
REQ-006 SHALL have port data, input, XLEN: store data, right-aligned.
REQ-007 SHALL have port fn3, input, 3: RISC-V load/store funct3.
REQ-008 SHALL have ports load and store, input, 1 each: request type.
REQ-009 SHALL have port new_request, input, 1: request strobe.
REQ-010 SHALL have port lsq_full, output, 1: queue cannot accept a request.
REQ-011 SHALL have port mem_addr, output, XLEN: word-aligned address, with addr[1:0] forced to 0.
REQ-012 SHALL have ports mem_wdata (output, XLEN), mem_be (output, 4), mem_rnw (output, 1), mem_req_valid (output, 1) and mem_req_ready (input, 1).
REQ-013 SHALL have ports mem_rdata (input, XLEN) and mem_rvalid (input, 1).
REQ-014 SHALL have ports load_data (output, XLEN), load_data_valid (output, 1) and load_data_ack (input, 1), forming a dataflow return path to the PR unit.

Function
REQ-015 SHALL enqueue {addr, data, fn3, load} on a clk edge where new_request=1, lsq_full=0 and exactly one of load/store is 1.
REQ-016 SHALL silently drop new_request when load=store, or when lsq_full=1 in that cycle.
REQ-017 SHALL drive lsq_full = (count==DEPTH), decoded from registered count with no same-cycle dequeue bypass.
REQ-018 SHALL wrap the head and tail pointers modulo DEPTH, and SHALL update count by +1, -1 or 0 when enqueue and dequeue occur together.
REQ-019 SHALL issue requests strictly in enqueue order, with at most one memory transaction outstanding.
REQ-020 SHALL implement the FSM states IDLE, ISSUE, WAIT_RD and RETURN:
- IDLE->ISSUE when count>0.
- ISSUE: mem_req_valid=1, fields taken from the head entry and held stable until mem_req_ready.
- On handshake, a store dequeues and goes to IDLE; a load goes to WAIT_RD.
- WAIT_RD->RETURN on mem_rvalid; the extracted result is registered.
- RETURN: load_data_valid=1; on load_data_ack, dequeue and go to IDLE.
REQ-021 SHALL generate mem_be from fn3[1:0] and addr[1:0]: byte 0001<<a, half 0011<<a (a in {0,2}), word 1111; mem_wdata SHALL replicate the byte or half across lanes.
REQ-022 SHALL, for loads, select the lane by addr[1:0], zero-extend when fn3[2]=1 and sign-extend otherwise.
REQ-023 SHALL NOT check misalignment; misaligned half/word accesses use addr[1:0] as given and are a caller error.
REQ-024 SHALL hold load_data stable while load_data_valid=1 and load_data_ack=0.
REQ-025 SHALL accept enqueue in every state, including while a transaction is outstanding.

Reset
REQ-026 SHALL, on rst=1, clear count and both pointers and set the state to IDLE.
REQ-027 SHALL, on rst=1, drive lsq_full=0, mem_req_valid=0, load_data_valid=0 and load_data=0 in the following cycle.
REQ-028 SHALL abandon any in-flight transaction on reset mid-operation, and SHALL ignore a late mem_rvalid arriving while in IDLE.
REQ-029 SHALL leave entry storage unreset.

Structure
REQ-030 SHALL place the lsq_entry_t struct {addr, data, fn3, is_load} and the FSM state enum in rca_config.
REQ-031 SHALL place the byte-enable generation and load extraction in one combinational sub-module, rca_lsq_align.

Verification
REQ-032 Store word: addr=0x100, data=0xDEADBEEF, fn3=010 -> mem_addr=0x100, mem_be=1111, mem_rnw=0; dequeued on mem_req_ready.
REQ-033 Load byte signed: addr=0x203, fn3=000, mem_rdata=0x80FFFFFF -> load_data=0xFFFFFF80; load_data_unsigned case: fn3=100 -> 0x00000080.
REQ-034 Fill test: 4 stores with mem_req_ready=0 -> lsq_full=1; a 5th request is dropped; releasing ready drains the 4 stores in order.
REQ-035 Back-pressure: a load completes with load_data_ack held 0 for 5 cycles -> load_data stable and the next entry not issued; ack -> next issue.
REQ-036 Reset while in WAIT_RD with 2 entries queued -> count=0, state IDLE, a later mem_rvalid ignored.
REQ-037 Invalid request: load=1, store=1 -> no enqueue, count unchanged.
